// File: rtl/adc_pkg.sv
// adc_pkg: command words, word width, controller state encoding and the
// offset-binary to two's-complement sample conversion shared by the ADC controller.
package adc_pkg;

    localparam int unsigned WORD_W = 16;

    // Bits [15:14] select the channel the ADC converts next: 2'b10 left, 2'b11 right.
    localparam logic [WORD_W-1:0] CMD_LEFT  = 16'h8000;
    localparam logic [WORD_W-1:0] CMD_RIGHT = 16'hC000;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPrime,
        StWait,
        StWordL,
        StWordR,
        StDone
    } adc_state_e;

    // Offset binary and two's complement differ only in the sign bit.
    function automatic logic [WORD_W-1:0] offset_to_signed(input logic [WORD_W-1:0] raw);
        return {~raw[WORD_W-1], raw[WORD_W-2:0]};
    endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// spi_word_shifter: generates SCK for one 16-bit word, shifting the command out on SDI
// (MSB first) and the ADC data in from SDO. A start coinciding with done chains the
// next word with no idle SCK cycles.
module spi_word_shifter
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] tx_word,
    input  logic              sdo,
    output logic              sck,
    output logic              sdi,
    output logic              done,
    output logic [WORD_W-1:0] rx_word
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    logic [DivW-1:0]   div_q;
    logic [3:0]        bit_q;
    logic              sck_q;
    logic              busy_q;
    logic [WORD_W-1:0] tx_q;
    logic [WORD_W-1:0] rx_q;
    logic              phase_end;

    assign phase_end = busy_q && (div_q == DivMax);
    // Last cycle of the high phase of bit 0: the received word is complete.
    assign done      = phase_end && sck_q && (bit_q == 4'd0);

    assign sck     = sck_q;
    assign sdi     = tx_q[WORD_W-1];
    assign rx_word = rx_q;

    // SCK phase divider, bit counter and the TX/RX shift registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            bit_q  <= 4'd0;
            sck_q  <= 1'b0;
            busy_q <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            // SDO is captured in the first cycle after SCK rises.
            if (busy_q && sck_q && (div_q == '0)) begin
                rx_q <= {rx_q[WORD_W-2:0], sdo};
            end
            if (start && (!busy_q || done)) begin
                busy_q <= 1'b1;
                sck_q  <= 1'b0;
                div_q  <= '0;
                bit_q  <= 4'd15;
                tx_q   <= tx_word;
            end else if (phase_end) begin
                div_q <= '0;
                if (!sck_q) begin
                    sck_q <= 1'b1;
                end else begin
                    sck_q <= 1'b0;
                    if (bit_q == 4'd0) begin
                        busy_q <= 1'b0;
                    end else begin
                        bit_q <= bit_q - 4'd1;
                        tx_q  <= {tx_q[WORD_W-2:0], 1'b0};
                    end
                end
            end else if (busy_q) begin
                div_q <= div_q + DivW'(1);
            end
        end
    end

endmodule

// File: rtl/adc_controller.sv
// adc_controller: sequences the stereo ADC over SPI (prime with a left command, then
// one left/right word pair per request) and presents signed 1.15 samples.
module adc_controller
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_req,
    input  logic              SDO,
    output logic              SCK,
    output logic              CS_,
    output logic              SDI,
    output logic              ready,
    output logic [WORD_W-1:0] left_sample,
    output logic [WORD_W-1:0] right_sample,
    output logic              sample_valid,
    output logic              overrun
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    adc_state_e        state_q;
    logic [CntW-1:0]   setup_q;
    logic [WORD_W-1:0] left_raw_q;
    logic [WORD_W-1:0] left_q;
    logic [WORD_W-1:0] right_q;
    logic              cs_n_q;
    logic              ready_q;
    logic              valid_q;
    logic              overrun_q;

    logic              shift_start;
    logic              shift_done;
    logic [WORD_W-1:0] shift_tx;
    logic [WORD_W-1:0] shift_rx;

    // Word starts: prime after setup, left word on an accepted request, and the right
    // word chained onto the end of the left one. Each word carries the next command.
    always_comb begin
        shift_start = ((state_q == StSetup) && (setup_q == CntMax)) ||
                      ((state_q == StWait) && sample_req) ||
                      ((state_q == StWordL) && shift_done);
        shift_tx    = (state_q == StWait) ? CMD_RIGHT : CMD_LEFT;
    end

    spi_word_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .start   (shift_start),
        .tx_word (shift_tx),
        .sdo     (SDO),
        .sck     (SCK),
        .sdi     (SDI),
        .done    (shift_done),
        .rx_word (shift_rx)
    );

    // Controller FSM with registered chip select, handshake and sample outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            setup_q    <= '0;
            left_raw_q <= '0;
            left_q     <= '0;
            right_q    <= '0;
            cs_n_q     <= 1'b1;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= sample_req && !ready_q;
            unique case (state_q)
                StIdle: begin
                    cs_n_q  <= 1'b0;
                    setup_q <= '0;
                    state_q <= StSetup;
                end
                StSetup: begin
                    if (setup_q == CntMax) begin
                        state_q <= StPrime;
                    end else begin
                        setup_q <= setup_q + CntW'(1);
                    end
                end
                StPrime: begin
                    if (shift_done) begin
                        state_q <= StWait;
                        ready_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (sample_req) begin
                        state_q <= StWordL;
                        ready_q <= 1'b0;
                    end
                end
                StWordL: begin
                    if (shift_done) begin
                        left_raw_q <= shift_rx;
                        state_q    <= StWordR;
                    end
                end
                StWordR: begin
                    if (shift_done) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // The shifter is idle here, so rx still holds the right word.
                    left_q  <= offset_to_signed(left_raw_q);
                    right_q <= offset_to_signed(shift_rx);
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= StWait;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign CS_          = cs_n_q;
    assign ready        = ready_q;
    assign left_sample  = left_q;
    assign right_sample = right_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_controller.sv
// tb_adc_controller: two controller instances (CLK_DIV=4 and 2) share one behavioural
// pipelined ADC model; directed vector table, random pairs, overrun, mid-word reset
// and a back-to-back sine run are checked against bench-computed expectations.
module tb_adc_controller;

    localparam int unsigned CD_A = 4;
    localparam int unsigned CD_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, req_a, req_b, sdo, sel_b;
    logic        sck_a, cs_a, sdi_a, ready_a, valid_a, ovr_a;
    logic        sck_b, cs_b, sdi_b, ready_b, valid_b, ovr_b;
    logic [15:0] left_a, right_a, left_b, right_b;

    adc_controller #(.CLK_DIV(CD_A)) dut_a (
        .clk(clk), .reset(rst_a), .sample_req(req_a), .SDO(sdo), .SCK(sck_a), .CS_(cs_a),
        .SDI(sdi_a), .ready(ready_a), .left_sample(left_a), .right_sample(right_a),
        .sample_valid(valid_a), .overrun(ovr_a)
    );

    adc_controller #(.CLK_DIV(CD_B)) dut_b (
        .clk(clk), .reset(rst_b), .sample_req(req_b), .SDO(sdo), .SCK(sck_b), .CS_(cs_b),
        .SDI(sdi_b), .ready(ready_b), .left_sample(left_b), .right_sample(right_b),
        .sample_valid(valid_b), .overrun(ovr_b)
    );

    // The selected instance drives the ADC bus; the other is held in reset.
    logic        sck_m, cs_m, sdi_m, ready_m, valid_m, ovr_m;
    logic [15:0] left_m, right_m;
    assign sck_m   = sel_b ? sck_b : sck_a;
    assign cs_m    = sel_b ? cs_b : cs_a;
    assign sdi_m   = sel_b ? sdi_b : sdi_a;
    assign ready_m = sel_b ? ready_b : ready_a;
    assign valid_m = sel_b ? valid_b : valid_a;
    assign ovr_m   = sel_b ? ovr_b : ovr_a;
    assign left_m  = sel_b ? left_b : left_a;
    assign right_m = sel_b ? right_b : right_a;

    // ---------------- ADC model: one-word pipeline, data for the previous command ----
    logic [15:0] l_tab [0:511];
    logic [15:0] r_tab [0:511];
    int          pidx = 0;          // pair whose data the ADC is currently returning
    int          sck_pulses = 0;
    logic [15:0] cmd_log [$];
    logic [15:0] cmd_sh = 16'h0;
    int          rise_cnt = 0;
    logic        word_end = 1'b0;
    logic [1:0]  pend_ch = 2'b00;
    logic [1:0]  out_ch = 2'b00;    // 2'b10 left, 2'b11 right, else no valid data
    logic [3:0]  out_pos = 4'd0;
    logic [15:0] cur_word;

    always @(posedge sck_m or negedge sck_m or posedge cs_m) begin
        if (cs_m) begin
            rise_cnt = 0;
            word_end = 1'b0;
            pend_ch  = 2'b00;
            out_ch   = 2'b00;
            out_pos  = 4'd0;
        end else if (sck_m) begin
            sck_pulses++;
            cmd_sh = {cmd_sh[14:0], sdi_m};
            rise_cnt++;
            if (rise_cnt == 16) begin
                cmd_log.push_back(cmd_sh);
                pend_ch  = cmd_sh[15:14];
                rise_cnt = 0;
                word_end = 1'b1;
            end
        end else begin
            if (word_end) begin
                if (out_ch == 2'b11) pidx++;
                out_ch   = pend_ch;
                out_pos  = 4'd0;
                word_end = 1'b0;
            end else begin
                out_pos = 4'(rise_cnt);
            end
        end
    end

    always_comb begin
        cur_word = 16'hA5A5;
        if (out_ch == 2'b10) cur_word = l_tab[pidx[8:0]];
        else if (out_ch == 2'b11) cur_word = r_tab[pidx[8:0]];
    end
    assign sdo = cur_word[4'd15 - out_pos];

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offset binary: code 32768 is zero, each code step is one LSB.
    function automatic logic [15:0] ref_signed(input logic [15:0] raw);
        int v;
        v = int'(raw) - 32768;
        return 16'(v);
    endfunction

    function automatic int cd_now();
        return sel_b ? int'(CD_B) : int'(CD_A);
    endfunction

    function automatic int log_at(input int i);
        if (i < cmd_log.size()) return int'(cmd_log[i]);
        return -1;
    endfunction

    task automatic set_req(input logic v);
        if (sel_b) req_b = v;
        else req_a = v;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".sck"}, int'(sck_m), 0);
        check({tag, ".cs_n"}, int'(cs_m), 1);
        check({tag, ".sdi"}, int'(sdi_m), 0);
        check({tag, ".ready"}, int'(ready_m), 0);
        check({tag, ".valid"}, int'(valid_m), 0);
        check({tag, ".overrun"}, int'(ovr_m), 0);
        check({tag, ".left"}, int'(left_m), 0);
        check({tag, ".right"}, int'(right_m), 0);
    endtask

    task automatic startup(input string tag);
        int c;
        int p0;
        int l0;
        p0 = sck_pulses;
        l0 = cmd_log.size();
        @(negedge clk);
        if (sel_b) rst_b = 1'b0;
        else rst_a = 1'b0;
        @(negedge clk);
        c = 1;
        check({tag, ".cs_fall"}, int'(cs_m), 0);
        while (!ready_m && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check({tag, ".ready_seen"}, int'(ready_m), 1);
        check({tag, ".ready_latency"}, c, 1 + 33 * cd_now());
        check({tag, ".prime_pulses"}, sck_pulses - p0, 16);
        check({tag, ".prime_cmd"}, log_at(l0), 16'h8000);
        check({tag, ".sck_idle"}, int'(sck_m), 0);
        check({tag, ".cs_held"}, int'(cs_m), 0);
    endtask

    task automatic do_pair(input string tag, input logic [15:0] raw_l, input logic [15:0] raw_r,
                           input logic [15:0] exp_l, input logic [15:0] exp_r);
        int c;
        int p0;
        int l0;
        l_tab[pidx[8:0]] = raw_l;
        r_tab[pidx[8:0]] = raw_r;
        p0 = sck_pulses;
        l0 = cmd_log.size();
        @(negedge clk);
        check({tag, ".ready"}, int'(ready_m), 1);
        set_req(1'b1);
        @(negedge clk);
        set_req(1'b0);
        c = 1;
        while (!valid_m && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check({tag, ".latency"}, c, 64 * cd_now() + 2);
        check({tag, ".left"}, int'(left_m), int'(exp_l));
        check({tag, ".right"}, int'(right_m), int'(exp_r));
        check({tag, ".pulses"}, sck_pulses - p0, 32);
        check({tag, ".cmd0"}, log_at(l0), 16'hC000);
        check({tag, ".cmd1"}, log_at(l0 + 1), 16'h8000);
        @(negedge clk);
        check({tag, ".valid_pulse"}, int'(valid_m), 0);
    endtask

    typedef struct {
        logic [15:0] raw_l;
        logic [15:0] raw_r;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t        vecs [4];
    logic [15:0] exp_lq [$];
    logic [15:0] exp_rq [$];

    initial begin
        logic [15:0] rl, rr;
        int          c, nvalid, novr, p0, issued, got, first_v, last_v, lv, rv;
        real         ph;

        vecs[0] = '{16'h9234, 16'h6DCC, 16'h1234, 16'hEDCC};
        vecs[1] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
        vecs[3] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};

        sel_b = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        startup("start_a");
        for (int i = 0; i < 4; i++) begin
            do_pair($sformatf("vec%0d", i), vecs[i].raw_l, vecs[i].raw_r, vecs[i].exp_l,
                    vecs[i].exp_r);
        end
        for (int i = 0; i < 6; i++) begin
            rl = 16'($urandom);
            rr = 16'($urandom);
            do_pair($sformatf("rand%0d", i), rl, rr, ref_signed(rl), ref_signed(rr));
        end

        // Request arriving mid-transfer is dropped and flagged.
        rl = 16'($urandom);
        rr = 16'($urandom);
        l_tab[pidx[8:0]] = rl;
        r_tab[pidx[8:0]] = rr;
        p0 = sck_pulses;
        nvalid = 0;
        novr = 0;
        @(negedge clk);
        set_req(1'b1);
        @(negedge clk);
        set_req(1'b0);
        c = 1;
        while (c < 300) begin
            @(negedge clk);
            c++;
            if (valid_m) begin
                nvalid++;
                check("ovr.left", int'(left_m), int'(ref_signed(rl)));
                check("ovr.right", int'(right_m), int'(ref_signed(rr)));
            end
            if (ovr_m) novr++;
            if (c == 11) check("ovr.pulse_time", int'(ovr_m), 1);
            if (c == 10) set_req(1'b1);
            else if (c == 11) set_req(1'b0);
        end
        check("ovr.pulse_count", novr, 1);
        check("ovr.valid_count", nvalid, 1);
        check("ovr.pulses", sck_pulses - p0, 32);
        check("ovr.ready_after", int'(ready_m), 1);

        // Reset during bit 7 of the right word aborts the pair.
        l_tab[pidx[8:0]] = 16'h1111;
        r_tab[pidx[8:0]] = 16'h2222;
        p0 = sck_pulses;
        nvalid = 0;
        @(negedge clk);
        set_req(1'b1);
        @(negedge clk);
        set_req(1'b0);
        c = 1;
        while (c < 48 * CD_A + 2) begin
            @(negedge clk);
            c++;
            if (valid_m) nvalid++;
        end
        check("rst.bit_position", sck_pulses - p0, 24);
        rst_a = 1'b1;
        @(negedge clk);
        check_reset_values("rst_mid");
        check("rst.no_valid", nvalid, 0);
        @(negedge clk);
        startup("restart_a");
        do_pair("after_rst", 16'h9234, 16'h6DCC, 16'h1234, 16'hEDCC);

        // Switch to the CLK_DIV=2 instance for a back-to-back run.
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        sel_b = 1'b1;
        @(negedge clk);
        check_reset_values("reset_b");
        startup("start_b");
        for (int k = 0; k < 100; k++) begin
            ph = 6.2831853 * k / 25.0;
            lv = 32768 + $rtoi(30000.0 * $sin(ph));
            rv = 32768 + $rtoi(12000.0 * $cos(3.0 * ph));
            l_tab[9'(pidx + k)] = 16'(lv);
            r_tab[9'(pidx + k)] = 16'(rv);
            exp_lq.push_back(ref_signed(16'(lv)));
            exp_rq.push_back(ref_signed(16'(rv)));
        end
        issued = 0;
        got = 0;
        c = 0;
        novr = 0;
        first_v = 0;
        last_v = 0;
        while (got < 100 && c < 100 * (64 * CD_B + 2) + 500) begin
            @(negedge clk);
            c++;
            if (valid_m) begin
                check($sformatf("sine%0d.left", got), int'(left_m), int'(exp_lq[got]));
                check($sformatf("sine%0d.right", got), int'(right_m), int'(exp_rq[got]));
                if (got == 0) first_v = c;
                last_v = c;
                got++;
            end
            if (ovr_m) novr++;
            if (req_b) req_b = 1'b0;
            else if (ready_m && issued < 100) begin
                req_b = 1'b1;
                issued++;
            end
        end
        check("sine.count", got, 100);
        check("sine.overruns", novr, 0);
        check("sine.pair_rate", last_v - first_v, 99 * (64 * CD_B + 2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
